// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared arbitration mode enum and default sizing for the stream mux
package mux_pkg;
  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  localparam int DEF_N     = 4;
  localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - fixed-priority or round-robin grant logic with last-served pointer
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int        N     = DEF_N,
  parameter arb_mode_e MODE  = ARB_RR,
  localparam int       SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] grant_idx
);

  logic [SEL_W-1:0] last;
  logic             found;
  int               cand;

  // Search order starts just past the last-served channel in RR mode, at 0 otherwise.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 0; k < N; k++) begin
      if (MODE == ARB_RR) cand = (int'(last) + 1 + k) % N;
      else                cand = k;
      if (!found && req[cand]) begin
        found           = 1'b1;
        grant[cand]     = 1'b1;
        grant_idx       = SEL_W'(cand);
      end
    end
  end

  // Reset to N-1 so the first search begins at channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                last <= SEL_W'(N - 1);
    else if (advance && found) last <= grant_idx;
  end

endmodule

// File: rtl/stream_mux_arb.sv
// rtl/stream_mux_arb.sv - N-to-1 stream multiplexer with registered output and handshake
module stream_mux_arb
  import mux_pkg::*;
#(
  parameter int        N     = DEF_N,
  parameter int        WIDTH = DEF_WIDTH,
  parameter arb_mode_e MODE  = ARB_RR,
  localparam int       SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]     in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SEL_W-1:0] out_sel
);

  logic [N-1:0]     grant;
  logic [SEL_W-1:0] grant_idx;
  logic             load_en;
  logic             any_req;
  logic [WIDTH-1:0] sel_data;

  assign load_en  = !out_valid || out_ready;
  assign any_req  = |in_valid;
  assign in_ready = rst_n ? (grant & {N{load_en}}) : '0;

  rr_arbiter #(
    .N    (N),
    .MODE (MODE)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (in_valid),
    .advance   (load_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // With nothing to load the output empties but keeps its last word visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (load_en) begin
      out_valid <= any_req;
      if (any_req) begin
        out_data <= sel_data;
        out_sel  <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_arb.sv
// tb/tb_stream_mux_arb.sv - randomized and directed checks of stream_mux_arb in both modes
module tb_stream_mux_arb;
  import mux_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  in_valid = '0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic [3:0] rr_in_ready, fx_in_ready;
  logic       rr_out_valid, fx_out_valid;
  logic [7:0] rr_out_data, fx_out_data;
  logic [1:0] rr_out_sel, fx_out_sel;

  int total = 0;
  int bad = 0;

  // Reference state: what the output stage should hold, plus the RR last-served channel.
  int         m_last;
  bit         m_rv, m_fv;
  logic [7:0] m_rd, m_fd;
  int         m_rs, m_fs;

  always #5 clk = ~clk;

  stream_mux_arb #(.N(4), .WIDTH(8), .MODE(ARB_RR)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(rr_in_ready),
    .out_valid(rr_out_valid), .out_ready(out_ready), .out_data(rr_out_data), .out_sel(rr_out_sel)
  );

  stream_mux_arb #(.N(4), .WIDTH(8), .MODE(ARB_FIXED)) u_fx (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(fx_in_ready),
    .out_valid(fx_out_valid), .out_ready(out_ready), .out_data(fx_out_data), .out_sel(fx_out_sel)
  );

  function automatic int rr_pick(logic [3:0] v, int last);
    for (int k = 1; k <= 4; k++) if (v[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  function automatic int fx_pick(logic [3:0] v);
    for (int k = 0; k < 4; k++) if (v[k]) return k;
    return -1;
  endfunction

  function automatic logic [7:0] ch(int g);
    return in_data[g*8 +: 8];
  endfunction

  function automatic logic [3:0] exp_ready(bit held, int g);
    logic [3:0] r;
    r = '0;
    if ((!held || out_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_last = 3;
    m_rv = 0; m_rd = '0; m_rs = 0;
    m_fv = 0; m_fd = '0; m_fs = 0;
  endtask

  task automatic model_edge();
    int gr, gf;
    gr = rr_pick(in_valid, m_last);
    gf = fx_pick(in_valid);
    if (!m_rv || out_ready) begin
      if (gr >= 0) begin m_rv = 1; m_rd = ch(gr); m_rs = gr; m_last = gr; end
      else m_rv = 0;
    end
    if (!m_fv || out_ready) begin
      if (gf >= 0) begin m_fv = 1; m_fd = ch(gf); m_fs = gf; end
      else m_fv = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 4'b1111;
    in_data = 32'h1312_1110;
    out_ready = 1'b1;
    model_reset();
    @(negedge clk);
    total++; if (rr_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", rr_out_valid); end
    total++; if (rr_out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h exp=00", rr_out_data); end
    total++; if (rr_out_sel !== 2'd0) begin bad++; $display("FAIL reset_out_sel got=%0d exp=0", rr_out_sel); end
    total++; if (rr_in_ready !== 4'b0 || fx_in_ready !== 4'b0) begin bad++; $display("FAIL reset_in_ready got=%b/%b exp=0000", rr_in_ready, fx_in_ready); end
    @(posedge clk);
    @(negedge clk);
    total++; if (rr_out_valid !== 1'b0) begin bad++; $display("FAIL reset_hold_valid got=%b exp=0", rr_out_valid); end
    rst_n = 1'b1;
  endtask

  task automatic test_rr_sequence();
    int seq [5] = '{0, 1, 2, 3, 0};
    in_valid = 4'b1111;
    in_data = 32'h1312_1110;
    out_ready = 1'b1;
    #1;
    total++; if (rr_in_ready !== 4'b0001) begin bad++; $display("FAIL rr_first_ready got=%b exp=0001", rr_in_ready); end
    for (int c = 0; c < 5; c++) begin
      tick();
      total++; if (rr_out_sel !== 2'(seq[c]) || rr_out_data !== 8'(8'h10 + seq[c]) || rr_out_valid !== 1'b1) begin
        bad++; $display("FAIL rr_seq[%0d] got sel=%0d data=%h v=%b exp sel=%0d data=%h v=1", c, rr_out_sel, rr_out_data, rr_out_valid, seq[c], 8'(8'h10 + seq[c]));
      end
      total++; if (fx_out_sel !== 2'd0 || fx_out_data !== 8'h10) begin bad++; $display("FAIL fx_all_seq[%0d] got sel=%0d data=%h exp sel=0 data=10", c, fx_out_sel, fx_out_data); end
    end
  endtask

  task automatic test_fixed();
    in_valid = 4'b1010;
    in_data = 32'h4433_2211;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++; if (fx_in_ready !== 4'b0010) begin bad++; $display("FAIL fx_ready[%0d] got=%b exp=0010", c, fx_in_ready); end
      total++; if (rr_in_ready !== exp_ready(m_rv, rr_pick(in_valid, m_last))) begin bad++; $display("FAIL rr_ready_1010[%0d] got=%b exp=%b", c, rr_in_ready, exp_ready(m_rv, rr_pick(in_valid, m_last))); end
      tick();
      total++; if (fx_out_sel !== 2'd1 || fx_out_data !== 8'h22) begin bad++; $display("FAIL fx_sel[%0d] got sel=%0d data=%h exp sel=1 data=22", c, fx_out_sel, fx_out_data); end
      total++; if (rr_out_sel !== 2'(m_rs) || rr_out_data !== m_rd) begin bad++; $display("FAIL rr_1010[%0d] got sel=%0d data=%h exp sel=%0d data=%h", c, rr_out_sel, rr_out_data, m_rs, m_rd); end
    end
  endtask

  task automatic test_backpressure();
    in_valid = 4'b0100;
    in_data = 32'h00A5_0000;
    out_ready = 1'b1;
    tick();
    total++; if (rr_out_data !== 8'hA5 || rr_out_sel !== 2'd2) begin bad++; $display("FAIL bp_load got data=%h sel=%0d exp data=a5 sel=2", rr_out_data, rr_out_sel); end
    out_ready = 1'b0;
    in_valid = 4'b1111;
    in_data = 32'hD4C3_B2A1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (rr_in_ready !== 4'b0 || fx_in_ready !== 4'b0) begin bad++; $display("FAIL bp_ready[%0d] got=%b/%b exp=0000", c, rr_in_ready, fx_in_ready); end
      tick();
      total++; if (rr_out_data !== 8'hA5 || rr_out_sel !== 2'd2 || rr_out_valid !== 1'b1) begin
        bad++; $display("FAIL bp_hold[%0d] got data=%h sel=%0d v=%b exp data=a5 sel=2 v=1", c, rr_out_data, rr_out_sel, rr_out_valid);
      end
    end
    out_ready = 1'b1;
    #1;
    total++; if (rr_in_ready !== 4'b1000) begin bad++; $display("FAIL bp_release_ready got=%b exp=1000", rr_in_ready); end
    tick();
    total++; if (rr_out_data !== 8'hD4 || rr_out_sel !== 2'd3 || rr_out_valid !== 1'b1) begin bad++; $display("FAIL bp_next got data=%h sel=%0d exp data=d4 sel=3", rr_out_data, rr_out_sel); end
    total++; if (fx_out_data !== 8'hA1 || fx_out_sel !== 2'd0) begin bad++; $display("FAIL bp_fx_next got data=%h sel=%0d exp data=a1 sel=0", fx_out_data, fx_out_sel); end
  endtask

  task automatic test_rr_wrap();
    do_reset();
    in_valid = 4'b1000;
    in_data = 32'h8877_6655;
    out_ready = 1'b1;
    tick();
    total++; if (rr_out_sel !== 2'd3) begin bad++; $display("FAIL wrap_setup got sel=%0d exp=3", rr_out_sel); end
    in_valid = 4'b1010;
    tick();
    total++; if (rr_out_sel !== 2'd1 || rr_out_data !== 8'h66) begin bad++; $display("FAIL wrap_first got sel=%0d data=%h exp sel=1 data=66", rr_out_sel, rr_out_data); end
    tick();
    total++; if (rr_out_sel !== 2'd3 || rr_out_data !== 8'h88) begin bad++; $display("FAIL wrap_second got sel=%0d data=%h exp sel=3 data=88", rr_out_sel, rr_out_data); end
  endtask

  task automatic test_idle();
    in_valid = 4'b0001;
    in_data = 32'h0000_005C;
    out_ready = 1'b1;
    tick();
    in_valid = 4'b0000;
    #1;
    total++; if (rr_in_ready !== 4'b0) begin bad++; $display("FAIL idle_ready got=%b exp=0000", rr_in_ready); end
    tick();
    total++; if (rr_out_valid !== 1'b0 || rr_out_data !== 8'h5C || rr_out_sel !== 2'd0) begin
      bad++; $display("FAIL idle_drop got v=%b data=%h sel=%0d exp v=0 data=5c sel=0", rr_out_valid, rr_out_data, rr_out_sel);
    end
  endtask

  task automatic test_async_reset();
    in_valid = 4'b0100;
    in_data = 32'h0077_0000;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (rr_out_valid !== 1'b0 || rr_out_data !== 8'h00 || fx_out_valid !== 1'b0) begin
      bad++; $display("FAIL async_rst got v=%b data=%h fxv=%b exp v=0 data=00 fxv=0", rr_out_valid, rr_out_data, fx_out_valid);
    end
    total++; if (rr_in_ready !== 4'b0) begin bad++; $display("FAIL async_rst_ready got=%b exp=0000", rr_in_ready); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 4'b1111;
    in_data = 32'h4433_2211;
    out_ready = 1'b1;
    tick();
    total++; if (rr_out_sel !== 2'd0 || rr_out_data !== 8'h11) begin bad++; $display("FAIL post_rst_grant got sel=%0d data=%h exp sel=0 data=11", rr_out_sel, rr_out_data); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      in_valid = 4'($urandom_range(0, 15));
      in_data = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      total++; if (rr_in_ready !== exp_ready(m_rv, rr_pick(in_valid, m_last))) begin bad++; $display("FAIL rnd_rr_ready[%0d] got=%b exp=%b", c, rr_in_ready, exp_ready(m_rv, rr_pick(in_valid, m_last))); end
      total++; if (fx_in_ready !== exp_ready(m_fv, fx_pick(in_valid))) begin bad++; $display("FAIL rnd_fx_ready[%0d] got=%b exp=%b", c, fx_in_ready, exp_ready(m_fv, fx_pick(in_valid))); end
      tick();
      total++; if (rr_out_valid !== m_rv || rr_out_data !== m_rd || rr_out_sel !== 2'(m_rs)) begin
        bad++; $display("FAIL rnd_rr_out[%0d] got v=%b d=%h s=%0d exp v=%b d=%h s=%0d", c, rr_out_valid, rr_out_data, rr_out_sel, m_rv, m_rd, m_rs);
      end
      total++; if (fx_out_valid !== m_fv || fx_out_data !== m_fd || fx_out_sel !== 2'(m_fs)) begin
        bad++; $display("FAIL rnd_fx_out[%0d] got v=%b d=%h s=%0d exp v=%b d=%h s=%0d", c, fx_out_valid, fx_out_data, fx_out_sel, m_fv, m_fd, m_fs);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rr_sequence();
    test_fixed();
    test_backpressure();
    test_rr_wrap();
    test_idle();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_mux_arb.md
STREAM_MUX_ARB -- requirements
Module: stream_mux_arb

Interface
REQ-001 Parameter N, default 4, SHALL set the number of input channels; legal range 2..16.
REQ-002 Parameter WIDTH, default 8, SHALL set the data width of every channel in bits; legal range 1..64.
REQ-003 Parameter MODE, default ARB_RR, SHALL select arbitration: ARB_FIXED (lowest index wins) or ARB_RR (round-robin).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 in_valid  input  N  SHALL carry the per-channel valid flag; bit i belongs to channel i.
REQ-007 in_data  input  N*WIDTH  SHALL carry the packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 in_ready  output  N  SHALL carry the per-channel ready flag; one-hot or zero.
REQ-009 out_valid  output  1  SHALL indicate that out_data holds a word.
REQ-010 out_ready  input  1  SHALL indicate that the downstream consumer accepts the word this cycle.
REQ-011 out_data  output  WIDTH  SHALL carry the registered selected word.
REQ-012 out_sel  output  SEL_W  SHALL carry the source channel index of out_data; SEL_W = $clog2(N).

Function
REQ-013 Input transfer on channel i SHALL occur when in_valid[i] and in_ready[i] are both 1 at a rising edge; output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-014 load_en SHALL be (!out_valid || out_ready); in_ready[i] SHALL be load_en AND grant[i], with grant combinational from in_valid and arbiter state.
REQ-015 grant SHALL be one-hot over requesting channels when any in_valid bit is 1, and SHALL be all-zero otherwise.
REQ-016 ARB_FIXED: grant SHALL go to the lowest-index channel with in_valid = 1.
REQ-017 ARB_RR: grant SHALL go to the first requesting channel found by searching from (last+1) mod N upward, wrapping from N-1 to 0.
REQ-018 The last-served pointer SHALL update to the granted index only on an input transfer; it SHALL hold otherwise.
REQ-019 On an input transfer, out_data and out_sel SHALL load the granted channel's data and index on the same edge, and out_valid SHALL become 1.
REQ-020 On load_en with no requester, out_valid SHALL become 0; out_data and out_sel SHALL hold their values.
REQ-021 While out_valid = 1 and out_ready = 0, out_data, out_sel and out_valid SHALL remain stable and in_ready SHALL be all-zero.
REQ-022 Latency SHALL be one cycle from input transfer to out_valid; throughput SHALL be one word per cycle with simultaneous consume and load.
REQ-023 A channel dropping in_valid before its transfer SHALL lose its grant with no state change.

Reset
REQ-024 While rst_n = 0, out_valid SHALL be 0, out_data all-zero, out_sel 0, and the RR pointer N-1, so channel 0 has first priority.
REQ-025 Reset assertion mid-transfer SHALL discard the held word immediately and asynchronously; in_ready SHALL be all-zero while rst_n = 0.
REQ-026 Release of rst_n SHALL be synchronised externally; the block SHALL accept transfers from the first edge after release.

Structure
REQ-027 Package mux_pkg SHALL define the arb_mode_e enum (ARB_FIXED, ARB_RR) and the default N and WIDTH constants.
REQ-028 Arbitration SHALL live in one sub-module, rr_arbiter, containing the grant logic and pointer register; stream_mux_arb SHALL contain the output register and handshake.

Verification (N=4, WIDTH=8)
REQ-029 RR, in_valid=4'b1111 held, out_ready=1, in_data ch i = 8'h10+i -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_data 8'h10,8'h11,8'h12,8'h13,8'h10.
REQ-030 FIXED, in_valid=4'b1010 held, out_ready=1 -> out_sel=1 every cycle; in_ready=4'b0010; channel 3 is never served.
REQ-031 Backpressure: output holds 8'hA5 from ch2, out_ready=0 for 3 cycles -> out_data=8'hA5, out_sel=2 stable, in_ready=0; after out_ready=1 the next word loads on the same edge.
REQ-032 RR wrap: pointer=3, only in_valid[3] and in_valid[1] set -> ch1 granted first, then ch3.
REQ-033 All in_valid=0 after one word with out_ready=1 -> out_valid falls to 0 one cycle later; out_data retains its last value.
REQ-034 rst_n pulsed low while out_valid=1 -> out_valid=0 and out_data=0 without a clock edge; the first post-reset grant goes to ch0.
